// File: rtl/alu_operand_seq.sv
// alu_operand_seq: input sequencer for the lab-board 4-bit ALU.
// Collects operand A, operand B and the opcode from the slide switches, one
// debounced button press per item. It drives them as registered ALU inputs
// and latches the ALU result and flags for the display stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sw                  operand switches (DATA_W)
//   op_sel              opcode switches (3)
//   btn                 raw "next" push-button (async, bouncy, active-high)
//   a_out, b_out        registered operands to ALU
//   ctrl_out            registered opcode to ALU
//   alu_res/car/of      combinational ALU result and flags
//   res_q, car_q, of_q  latched ALU result and flags
//   valid               latched result belongs to current operand set
//   state_o             FSM state code for debug LEDs
module alu_operand_seq #(
    parameter int unsigned DATA_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic [2:0]        op_sel,
    input  logic              btn,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [2:0]        ctrl_out,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_car,
    input  logic              alu_of,
    output logic [DATA_W-1:0] res_q,
    output logic              car_q,
    output logic              of_q,
    output logic              valid,
    output logic [2:0]        state_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GOT_A = 3'd1,
        GOT_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Button synchroniser, debouncer and rising-edge detector
    logic             s1_q, s2_q;
    logic             db_q, db_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            db_dly_q <= db_q;
            if (s2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                db_q  <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // One-cycle pulse per accepted rising level; releases produce nothing
    assign press_c = db_q & ~db_dly_q;

    // Sequencer state and captured registers
    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_r_q, res_r_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              car_r_q, car_r_d, of_r_q, of_r_d, valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        res_r_d = res_r_q;
        car_r_d = car_r_q;
        of_r_d  = of_r_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (press_c) begin
                    a_d     = sw;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (press_c) begin
                    b_d     = sw;
                    state_d = GOT_B;
                end
            end
            GOT_B: begin
                if (press_c) begin
                    ctrl_d  = op_sel;
                    state_d = EXEC;
                end
            end
            // ALU inputs settled on the previous edge; a press here is dropped
            EXEC: begin
                res_r_d = alu_res;
                car_r_d = alu_car;
                of_r_d  = alu_of;
                valid_d = 1'b1;
                state_d = DONE;
            end
            // New operand set starts; B and opcode keep old values until recaptured
            DONE: begin
                if (press_c) begin
                    valid_d = 1'b0;
                    a_d     = sw;
                    state_d = GOT_A;
                end
            end
            // Unused encodings recover to IDLE without touching any register
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_r_q <= '0;
            car_r_q <= 1'b0;
            of_r_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_r_q <= res_r_d;
            car_r_q <= car_r_d;
            of_r_q  <= of_r_d;
            valid_q <= valid_d;
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign ctrl_out = ctrl_q;
    assign res_q    = res_r_q;
    assign car_q    = car_r_q;
    assign of_q     = of_r_q;
    assign valid    = valid_q;
    assign state_o  = 3'(state_q);

endmodule

// File: tb/tb_alu_operand_seq.sv
// Testbench for alu_operand_seq with DEBOUNCE_CYCLES=4 and an ALU model in loop.
module tb_alu_operand_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [2:0] op_sel;
    logic       btn;
    logic [3:0] a_out, b_out, alu_res, res_q;
    logic [2:0] ctrl_out, state_o;
    logic       alu_car, alu_of, car_q, of_q, valid;

    alu_operand_seq #(.DATA_W(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op_sel(op_sel), .btn(btn),
        .a_out(a_out), .b_out(b_out), .ctrl_out(ctrl_out),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .res_q(res_q), .car_q(car_q), .of_q(of_q), .valid(valid),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ALU environment: sub carry = no borrow, compare = (a<b), equal = (a==b)
    logic [4:0] tmp;
    always_comb begin
        tmp     = 5'd0;
        alu_res = 4'd0;
        alu_car = 1'b0;
        alu_of  = 1'b0;
        case (ctrl_out)
            3'b000: begin
                tmp = {1'b0, a_out} + {1'b0, b_out};
                alu_res = tmp[3:0]; alu_car = tmp[4];
                alu_of = (a_out[3] == b_out[3]) && (tmp[3] != a_out[3]);
            end
            3'b001: begin
                tmp = {1'b0, a_out} + {1'b0, ~b_out} + 5'd1;
                alu_res = tmp[3:0]; alu_car = tmp[4];
                alu_of = (a_out[3] != b_out[3]) && (tmp[3] != a_out[3]);
            end
            3'b010: alu_res = ~a_out;
            3'b011: alu_res = a_out & b_out;
            3'b100: alu_res = a_out | b_out;
            3'b101: alu_res = a_out ^ b_out;
            3'b110: alu_res = {3'b000, (a_out < b_out)};
            default: alu_res = {3'b000, (a_out == b_out)};
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] res;
        logic       car;
        logic       of;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       car;
        logic       of;
    } vec_t;

    exp_t sb[$];
    logic valid_seen = 1'b0;

    // Scoreboard: on each rising valid, compare latched result against queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid && !valid_seen) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_res", 32'(res_q), 32'(e.res));
                chk("sb_car", 32'(car_q), 32'(e.car));
                chk("sb_of",  32'(of_q),  32'(e.of));
            end
        end
        valid_seen = rst_n ? valid : 1'b0;
    end

    task automatic press(input logic [3:0] s, input logic [2:0] o);
        @(negedge clk);
        sw = s; op_sel = o; btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        logic found;
        vecs[0] = '{a: 4'h3, b: 4'h1, op: 3'b001, res: 4'h2, car: 1'b1, of: 1'b0};
        vecs[1] = '{a: 4'hF, b: 4'h1, op: 3'b000, res: 4'h0, car: 1'b1, of: 1'b0};
        vecs[2] = '{a: 4'h1, b: 4'h2, op: 3'b001, res: 4'hF, car: 1'b0, of: 1'b0};
        vecs[3] = '{a: 4'h8, b: 4'h1, op: 3'b001, res: 4'h7, car: 1'b1, of: 1'b1};
        vecs[4] = '{a: 4'hC, b: 4'hA, op: 3'b011, res: 4'h8, car: 1'b0, of: 1'b0};
        vecs[5] = '{a: 4'hC, b: 4'hA, op: 3'b101, res: 4'h6, car: 1'b0, of: 1'b0};
        vecs[6] = '{a: 4'h5, b: 4'h2, op: 3'b010, res: 4'hA, car: 1'b0, of: 1'b0};
        vecs[7] = '{a: 4'h2, b: 4'h9, op: 3'b110, res: 4'h1, car: 1'b0, of: 1'b0};

        rst_n = 1'b0; btn = 1'b0; sw = 4'h0; op_sel = 3'b000;
        #12;
        chk("rst_state", 32'(state_o), 32'(0));
        chk("rst_a", 32'(a_out), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_res", 32'({res_q, car_q, of_q}), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_state", 32'(state_o), 32'(0));

        // Bounce: 2 high, 1 low, 3 high, low -> no press
        btn = 1'b1; repeat (2) @(negedge clk);
        btn = 1'b0; @(negedge clk);
        btn = 1'b1; repeat (3) @(negedge clk);
        btn = 1'b0; repeat (12) @(negedge clk);
        chk("bounce_state", 32'(state_o), 32'(0));

        // First real press: state changes exactly on edge 7
        sw = 4'h7; btn = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("edge6_state", 32'(state_o), 32'(0));
        @(posedge clk);
        #1 chk("edge7_state", 32'(state_o), 32'(1));
        chk("capture_a", 32'(a_out), 32'(7));
        repeat (4) @(negedge clk);
        btn = 1'b0; repeat (12) @(negedge clk);
        chk("one_press_state", 32'(state_o), 32'(1));

        press(4'h1, 3'b000);
        chk("capture_b", 32'(b_out), 32'(1));
        chk("gotb_state", 32'(state_o), 32'(2));

        // Opcode press with result latency check (add with overflow)
        @(negedge clk);
        op_sel = 3'b000; btn = 1'b1;
        sb.push_back('{res: 4'h8, car: 1'b0, of: 1'b1});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1 if (state_o == 3'd3) found = 1'b1;
        end
        chk("exec_reached", 32'(found), 32'(1));
        chk("exec_valid", 32'(valid), 32'(0));
        chk("capture_op", 32'(ctrl_out), 32'(0));
        @(posedge clk);
        #1 chk("done_state", 32'(state_o), 32'(4));
        chk("done_valid", 32'(valid), 32'(1));
        chk("add_res", 32'(res_q), 32'(8));
        chk("add_of", 32'(of_q), 32'(1));
        @(negedge clk); btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("done_hold", 32'(state_o), 32'(4));

        // Table-driven operand sets
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].a, 3'b000);
            press(vecs[i].b, 3'b000);
            sb.push_back('{res: vecs[i].res, car: vecs[i].car, of: vecs[i].of});
            press(4'h0, vecs[i].op);
            chk($sformatf("vec%0d_a", i), 32'(a_out), 32'(vecs[i].a));
            chk($sformatf("vec%0d_b", i), 32'(b_out), 32'(vecs[i].b));
            chk($sformatf("vec%0d_op", i), 32'(ctrl_out), 32'(vecs[i].op));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(1));
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(4));
        end

        // Restart from DONE
        press(4'hA, 3'b011);
        chk("restart_valid", 32'(valid), 32'(0));
        chk("restart_a", 32'(a_out), 32'(4'hA));
        chk("restart_state", 32'(state_o), 32'(1));
        chk("restart_b_kept", 32'(b_out), 32'(vecs[7].b));
        chk("restart_op_kept", 32'(ctrl_out), 32'(vecs[7].op));

        // Reset in GOT_B, asserted mid-cycle
        press(4'h4, 3'b000);
        chk("pre_rst_state", 32'(state_o), 32'(2));
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midrst_a", 32'(a_out), 32'(0));
        chk("midrst_b", 32'(b_out), 32'(0));
        chk("midrst_state", 32'(state_o), 32'(0));
        chk("midrst_op", 32'(ctrl_out), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        press(4'h5, 3'b000);
        chk("postrst_a", 32'(a_out), 32'(5));
        chk("postrst_state", 32'(state_o), 32'(1));
        chk("postrst_b", 32'(b_out), 32'(0));

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
